// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receive front end.
// Synchronises rxd, samples each bit mid-period, and strobes each good byte out
// with a one-cycle word_valid. It also reports line activity, link status and
// framing errors.
// Compile-time option: define UART_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int IDLE_BITS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] word,
    output logic       word_valid,
    output logic       word_on_line,
    output logic       connection_status,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int HALF     = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(IDLE_MAX);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_RECOVER = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY  = 3'd5
`endif
    } state_t;

    logic               r_sync1;
    logic               r_rxd_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_clk_cnt;
    logic [CNT_W-1:0]   w_clk_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic               w_cnt_last;
    logic               w_stop_sample;

    logic [7:0]         r_word;
    logic [7:0]         w_word_nxt;
    logic               r_word_valid;
    logic               w_word_valid_nxt;
    logic               r_word_on_line;
    logic               r_conn;
    logic               w_conn_nxt;
    logic               r_frame_err;
    logic               w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bad;
    logic               w_par_bad_nxt;
    logic               r_parity_err;
    logic               w_parity_err_nxt;
`endif

    assign w_cnt_last    = (r_clk_cnt == CNT_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_cnt_last;

    // Two-flop synchroniser; rxd_s is the only view of the line used below.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
        end
    end

    // Count consecutive idle-high cycles, saturating at the connect threshold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idle_cnt <= '0;
        end else if (!r_rxd_s) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_SAT) begin
            r_idle_cnt <= r_idle_cnt + IDLE_ONE;
        end
    end

    // State register with the bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    // Next-state logic: start-bit qualification at mid-bit, then one sample per bit period.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rxd_s) begin
                    w_state_nxt   = S_START;
                    w_clk_cnt_nxt = '0;
                end
            end
            S_START: begin
                if (r_clk_cnt == CNT_MID) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    // A line that is back high at mid-start was a glitch.
                    w_state_nxt   = r_rxd_s ? S_IDLE : S_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_shift_nxt[r_bit_idx] = r_rxd_s;
                    w_clk_cnt_nxt          = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_last) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    w_par_bad_nxt = r_rxd_s ^ (^r_shift);
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_last) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = r_rxd_s ? S_IDLE : S_RECOVER;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            S_RECOVER: begin
                if (r_rxd_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: deliver the byte or flag the error at the stop-bit sample.
    always_comb begin
        w_word_nxt       = r_word;
        w_word_valid_nxt = 1'b0;
        w_frame_err_nxt  = r_frame_err;
        w_conn_nxt       = r_conn | (r_idle_cnt == IDLE_SAT);
`ifdef UART_RX_PARITY_EN
        w_parity_err_nxt = r_parity_err;
`endif
        if (w_stop_sample) begin
            if (!r_rxd_s) begin
                w_frame_err_nxt = 1'b1;
                w_conn_nxt      = 1'b0;
`ifdef UART_RX_PARITY_EN
                w_parity_err_nxt = r_par_bad;
            end else if (r_par_bad) begin
                w_frame_err_nxt  = 1'b1;
                w_parity_err_nxt = 1'b1;
`endif
            end else begin
                w_word_nxt       = r_shift;
                w_word_valid_nxt = 1'b1;
                w_frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
                w_parity_err_nxt = 1'b0;
`endif
            end
        end
    end

    // Output registers; word_on_line tracks the state register edge for edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word         <= 8'h00;
            r_word_valid   <= 1'b0;
            r_word_on_line <= 1'b0;
            r_conn         <= 1'b0;
            r_frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err   <= 1'b0;
`endif
        end else begin
            r_word         <= w_word_nxt;
            r_word_valid   <= w_word_valid_nxt;
            r_word_on_line <= (w_state_nxt != S_IDLE);
            r_conn         <= w_conn_nxt;
            r_frame_err    <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_parity_err   <= w_parity_err_nxt;
`endif
        end
    end

    assign word              = r_word;
    assign word_valid        = r_word_valid;
    assign word_on_line      = r_word_on_line;
    assign connection_status = r_conn;
    assign frame_err         = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err        = r_parity_err;
`else
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer (CLKS_PER_BIT=8, IDLE_BITS=10).
// Stimulus tasks push expected bytes and strobe cycles into a queue; a
// separate monitor pops and compares on every word_valid strobe.
// Parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deframer;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 86;
`else
    localparam int LAT = 78;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] word;
    logic       word_valid;
    logic       word_on_line;
    logic       connection_status;
    logic       frame_err;
    logic       parity_err;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int t_k      = 0;
    int t_g      = 0;
    int c0       = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    uart_rx_deframer #(
        .CLKS_PER_BIT(CPB),
        .IDLE_BITS   (10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rxd              (rxd),
        .word             (word),
        .word_valid       (word_valid),
        .word_on_line     (word_on_line),
        .connection_status(connection_status),
        .frame_err        (frame_err),
        .parity_err       (parity_err)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_word"}, 32'(word), 32'h00);
        check({tag, "_valid"}, 32'(word_valid), 0);
        check({tag, "_on_line"}, 32'(word_on_line), 0);
        check({tag, "_conn"}, 32'(connection_status), 0);
        check({tag, "_frame_err"}, 32'(frame_err), 0);
        check({tag, "_parity_err"}, 32'(parity_err), 0);
    endtask

    // Drive one frame, LSB first. Must be called 1 time unit after a rising edge.
    // The first edge that samples the start bit is cyc+1.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
        exp_t e;
        t_k = cyc + 1;
        if (stop_bit && par_ok) begin
            e.data = d;
            e.at   = t_k + LAT;
            exp_q.push_back(e);
        end
        rxd = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            hold(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_ok ? ^d : ~(^d);
        hold(CPB);
`endif
        rxd = stop_bit;
        hold(CPB);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected byte and cycle.
    always @(negedge clk) begin
        if (word_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: word %0h at cycle %0d, no strobe expected", word, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_word", 32'(word), 32'(mon_e.data));
                check("strobe_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        rst = 1'b0;
        rxd = 1'b1;
        hold(5);
        check_reset_values("reset");
        rst = 1'b1;
        c0  = cyc;

        // Connection status after 80 idle cycles, and not before.
        wait_cyc(c0 + 79);
        check("conn_early", 32'(connection_status), 0);
        wait_cyc(c0 + 83);
        check("conn_set", 32'(connection_status), 1);
        align();

        // Byte A5: exact strobe cycle via scoreboard, word_on_line window.
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                @(negedge clk);
                wait_cyc(t_k + 1);
                check("a5_on_line_k1", 32'(word_on_line), 0);
                wait_cyc(t_k + 2);
                check("a5_on_line_k2", 32'(word_on_line), 1);
                wait_cyc(t_k + 77);
                check("a5_on_line_k77", 32'(word_on_line), 1);
                wait_cyc(t_k + LAT);
                check("a5_on_line_done", 32'(word_on_line), 0);
            end
        join
        check("a5_word", 32'(word), 32'hA5);
        check("a5_conn_kept", 32'(connection_status), 1);

        // Two-cycle low glitch: rejected in START.
        hold(20);
        t_g = cyc + 1;
        rxd = 1'b0;
        hold(2);
        rxd = 1'b1;
        wait_cyc(t_g + 3);
        check("glitch_start", 32'(word_on_line), 1);
        wait_cyc(t_g + 12);
        check("glitch_idle", 32'(word_on_line), 0);
        check("glitch_frame_err", 32'(frame_err), 0);
        check("glitch_conn", 32'(connection_status), 1);
        align();

        // Byte 3C with a low stop bit, line held low, then a good 81.
        hold(10);
        send_frame(8'h3C, 1'b0, 1'b1);
        check("ferr_set", 32'(frame_err), 1);
        check("ferr_conn", 32'(connection_status), 0);
        check("ferr_word_held", 32'(word), 32'hA5);
        hold(40);
        check("ferr_recover", 32'(word_on_line), 1);
        check("ferr_recover_conn", 32'(connection_status), 0);
        rxd = 1'b1;
        hold(20);
        check("ferr_back_idle", 32'(word_on_line), 0);
        check("ferr_sticky", 32'(frame_err), 1);
        send_frame(8'h81, 1'b1, 1'b1);
        check("x81_word", 32'(word), 32'h81);
        check("x81_frame_err", 32'(frame_err), 0);
        check("x81_conn", 32'(connection_status), 0);

        // Back-to-back 00 then FF with no idle gap: strobes 80 cycles apart.
        hold(10);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        check("b2b_word", 32'(word), 32'hFF);

`ifdef UART_RX_PARITY_EN
        // Wrong parity on 07, then the correct parity.
        hold(20);
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_bad_perr", 32'(parity_err), 1);
        check("par_bad_ferr", 32'(frame_err), 1);
        check("par_bad_word", 32'(word), 32'hFF);
        hold(20);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_word", 32'(word), 32'h07);
        check("par_ok_perr", 32'(parity_err), 0);
        check("par_ok_ferr", 32'(frame_err), 0);
`endif

        // Reset in the middle of a frame.
        rxd = 1'b1;
        hold(100);
        check("pre_rst_conn", 32'(connection_status), 1);
        rxd = 1'b0;
        hold(CPB);
        rxd = 1'b1;
        hold(20);
        check("pre_rst_on_line", 32'(word_on_line), 1);
        rst = 1'b0;
        hold(1);
        check_reset_values("midrst");
        rst = 1'b1;
        rxd = 1'b1;
        hold(100);
        check("post_rst_on_line", 32'(word_on_line), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
